cv32e40x_div_ctrl: RTL

CV32E40X_DIV_CTRL -- requirements
Module: cv32e40x_div_ctrl

---
 rtl/cv32e40x_pkg.sv | 23 ++
 rtl/cv32e40x_ff_one.sv | 20 ++
 rtl/cv32e40x_div_ctrl.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/cv32e40x_pkg.sv
// Shared types for the divider controller: ALU opcodes, controller states and iteration limit.
package cv32e40x_pkg;

  localparam int DIV_ITER_MAX = 32;

  typedef enum logic [5:0] {
    ALU_ADD  = 6'b011000,
    ALU_SUB  = 6'b011001,
    ALU_XOR  = 6'b101111,
    ALU_DIVU = 6'b110100,
    ALU_DIV  = 6'b110101,
    ALU_REMU = 6'b110110,
    ALU_REM  = 6'b110111
  } alu_opcode_e;

  typedef enum logic [1:0] {
    DIV_IDLE    = 2'd0,
    DIV_SPECIAL = 2'd1,
    DIV_ITER    = 2'd2,
    DIV_DONE    = 2'd3
  } div_ctrl_state_e;

endpackage

// File: rtl/cv32e40x_ff_one.sv
// Find-first-one: index of the lowest set bit of in_i, plus an all-zero flag.
// Purely combinational, no handshake.
module cv32e40x_ff_one #(
  parameter int LEN = 32
) (
  input  logic [LEN-1:0]         in_i,
  output logic [$clog2(LEN)-1:0] first_one_o,
  output logic                   no_ones_o
);

  always_comb begin
    first_one_o = '0;
    for (int i = LEN - 1; i >= 0; i--) begin
      if (in_i[i]) first_one_o = ($clog2(LEN))'(i);
    end
  end

  assign no_ones_o = ~|in_i;

endmodule

// File: rtl/cv32e40x_div_ctrl.sv
// Iterative divider sequencer: special results after 1 cycle, normal results after N+1 cycles.
// Holds the result until out_ready_i; accepts a new request only from IDLE without kill.
module cv32e40x_div_ctrl
  import cv32e40x_pkg::*;
#(
  parameter int DIV_ITER_MAX = cv32e40x_pkg::DIV_ITER_MAX
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  alu_opcode_e operator_i,
  input  logic [31:0] op_a_i,
  input  logic [31:0] op_b_i,
  input  logic        kill_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [31:0] result_o,
  output logic        dp_start_o,
  output logic        dp_step_o,
  output logic        dp_clear_o,
  input  logic [31:0] dp_result_i
);

  localparam logic [5:0] ITER_MAX = 6'(DIV_ITER_MAX);

  div_ctrl_state_e state_q, state_d;
  logic [5:0]      cnt_q, cnt_d;
  alu_opcode_e     op_q;
  logic [31:0]     op_a_q, op_b_q, result_q;
  logic            captured_q;

  logic        op_legal, op_signed, overflow, special, accept;
  logic [31:0] mag, mag_rev;
  logic [4:0]  first_one;
  logic        no_ones;
  logic [5:0]  n_bits, n_iter;
  logic        is_rem, div_by_zero;
  logic [31:0] special_res;

  assign op_legal  = operator_i inside {ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU};
  assign op_signed = (operator_i == ALU_DIV) || (operator_i == ALU_REM);
  assign mag       = (op_signed && op_a_i[31]) ? -op_a_i : op_a_i;

  // Lowest set bit of the reversed magnitude is the dividend's MSB position.
  always_comb begin
    mag_rev = '0;
    for (int i = 0; i < 32; i++) mag_rev[i] = mag[31-i];
  end

  cv32e40x_ff_one #(.LEN(32)) u_ff_one (
    .in_i        (mag_rev),
    .first_one_o (first_one),
    .no_ones_o   (no_ones)
  );

  assign n_bits   = 6'd32 - {1'b0, first_one};
  assign n_iter   = (n_bits > ITER_MAX) ? ITER_MAX : n_bits;
  assign overflow = op_signed && (op_a_i == 32'h8000_0000) && (op_b_i == 32'hFFFF_FFFF);
  assign special  = (op_b_i == '0) || no_ones || overflow;

  assign in_ready_o = (state_q == DIV_IDLE) && !kill_i;
  assign accept     = in_valid_i && in_ready_o && op_legal;
  assign dp_start_o = accept && !special;
  assign dp_step_o  = (state_q == DIV_ITER) && !kill_i;
  assign dp_clear_o = kill_i && ((state_q == DIV_ITER) || (state_q == DIV_DONE));
  assign out_valid_o = ((state_q == DIV_SPECIAL) || (state_q == DIV_DONE)) && !kill_i;

  // Every special case reduces to: quotient is all-ones on /0, else the dividend itself.
  assign is_rem      = (op_q == ALU_REM) || (op_q == ALU_REMU);
  assign div_by_zero = (op_b_q == '0);
  assign special_res = is_rem ? (div_by_zero ? op_a_q : 32'h0)
                              : (div_by_zero ? 32'hFFFF_FFFF : op_a_q);

  always_comb begin
    result_o = '0;
    if (out_valid_o) begin
      if (state_q == DIV_SPECIAL) result_o = special_res;
      else                        result_o = captured_q ? result_q : dp_result_i;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      DIV_IDLE: begin
        if (accept) begin
          state_d = special ? DIV_SPECIAL : DIV_ITER;
          cnt_d   = special ? 6'd0 : n_iter;
        end
      end
      DIV_SPECIAL: if (out_ready_i) state_d = DIV_IDLE;
      DIV_ITER: begin
        cnt_d = cnt_q - 6'd1;
        if (cnt_q == 6'd1) state_d = DIV_DONE;
      end
      DIV_DONE: if (out_ready_i) state_d = DIV_IDLE;
      default: state_d = DIV_IDLE;
    endcase
    if (kill_i) begin
      state_d = DIV_IDLE;
      cnt_d   = 6'd0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= DIV_IDLE;
      cnt_q      <= 6'd0;
      op_q       <= ALU_DIV;
      op_a_q     <= '0;
      op_b_q     <= '0;
      result_q   <= '0;
      captured_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        op_q   <= operator_i;
        op_a_q <= op_a_i;
        op_b_q <= op_b_i;
      end
      // dp_result_i is only valid in the first DONE cycle, so latch it there.
      if (state_q == DIV_DONE && !captured_q && !kill_i) begin
        result_q   <= dp_result_i;
        captured_q <= 1'b1;
      end
      if (state_d == DIV_IDLE) begin
        result_q   <= '0;
        captured_q <= 1'b0;
      end
    end
  end

  a_legal_op : assert property (@(posedge clk) disable iff (!rst_n)
                                (in_valid_i && in_ready_o) |-> op_legal)
    else $error("illegal divider operator");

endmodule
